// File: rtl/piggy_bank.sv
// Coin-accumulating credit register with priority-ordered item purchase deduction.
// Deposits saturate at 255; a purchase is taken only if the running balance covers its price.
module piggy_bank (
    input  logic       clk,
    input  logic       reset,
    input  logic       penny,
    input  logic       nickel,
    input  logic       dime,
    input  logic       quarter,
    input  logic       apple,
    input  logic       banana,
    input  logic       carrot,
    input  logic       date,
    output logic [7:0] credit
);

    localparam logic [9:0] PENNY_VAL    = 10'd1;
    localparam logic [9:0] NICKEL_VAL   = 10'd5;
    localparam logic [9:0] DIME_VAL     = 10'd10;
    localparam logic [9:0] QUARTER_VAL  = 10'd25;
    localparam logic [9:0] CREDIT_MAX   = 10'd255;

    localparam logic [7:0] APPLE_PRICE  = 8'd75;
    localparam logic [7:0] BANANA_PRICE = 8'd20;
    localparam logic [7:0] CARROT_PRICE = 8'd30;
    localparam logic [7:0] DATE_PRICE   = 8'd40;

    logic [7:0] credit_q;
    logic [7:0] credit_d;
    logic [9:0] dep;
    logic [9:0] sum;
    logic [7:0] bal;

    // NOTE: blocking assignments here model the ordered chain of deductions;
    // each step reads the balance already reduced by the step before it.
    always_comb begin
        dep = 10'd0;
        if (penny)   dep = dep + PENNY_VAL;
        if (nickel)  dep = dep + NICKEL_VAL;
        if (dime)    dep = dep + DIME_VAL;
        if (quarter) dep = dep + QUARTER_VAL;

        sum = {2'b00, credit_q} + dep;
        bal = (sum > CREDIT_MAX) ? 8'd255 : sum[7:0];

        if (apple  && (bal >= APPLE_PRICE))  bal = bal - APPLE_PRICE;
        if (banana && (bal >= BANANA_PRICE)) bal = bal - BANANA_PRICE;
        if (carrot && (bal >= CARROT_PRICE)) bal = bal - CARROT_PRICE;
        if (date   && (bal >= DATE_PRICE))   bal = bal - DATE_PRICE;

        credit_d = bal;
    end

    // NOTE: reset is sampled on the clock edge only and overrides every coin and item input.
    always_ff @(posedge clk) begin
        if (reset) begin
            credit_q <= 8'd0;
        end else begin
            credit_q <= credit_d;
        end
    end

    assign credit = credit_q;

endmodule

// File: tb/tb_piggy_bank.sv
// Self-checking bench for piggy_bank: directed scenarios plus a randomized run,
// with expected credit values queued at drive time and compared one cycle later.
module tb_piggy_bank;

    localparam logic [7:0] P  = 8'h01;
    localparam logic [7:0] N  = 8'h02;
    localparam logic [7:0] D  = 8'h04;
    localparam logic [7:0] Q  = 8'h08;
    localparam logic [7:0] A  = 8'h10;
    localparam logic [7:0] B  = 8'h20;
    localparam logic [7:0] C  = 8'h40;
    localparam logic [7:0] DT = 8'h80;

    logic       clk;
    logic       reset;
    logic       penny, nickel, dime, quarter;
    logic       apple, banana, carrot, date;
    logic [7:0] credit;

    int         checks;
    int         errors;
    logic [7:0] exp_q[$];

    piggy_bank dut (
        .clk     (clk),
        .reset   (reset),
        .penny   (penny),
        .nickel  (nickel),
        .dime    (dime),
        .quarter (quarter),
        .apple   (apple),
        .banana  (banana),
        .carrot  (carrot),
        .date    (date),
        .credit  (credit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, queue the expected credit, and advance past the edge.
    task automatic apply(input logic rst, input logic [7:0] v, input logic [7:0] expected);
        reset   = rst;
        penny   = v[0];
        nickel  = v[1];
        dime    = v[2];
        quarter = v[3];
        apple   = v[4];
        banana  = v[5];
        carrot  = v[6];
        date    = v[7];
        exp_q.push_back(expected);
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input string name, input logic [7:0] stim[], input logic [7:0] want[]);
        logic [7:0] e;
        for (int i = 0; i < stim.size(); i++) begin
            apply(1'b0, stim[i], want[i]);
            e = exp_q.pop_front();
            checks++;
            if (credit !== e) begin
                errors++;
                $display("FAIL %s step %0d: credit=%0d expected=%0d", name, i, credit, e);
            end
        end
    endtask

    task automatic do_reset(input string name);
        logic [7:0] e;
        apply(1'b1, 8'h00, 8'd0);
        e = exp_q.pop_front();
        checks++;
        if (credit !== e) begin
            errors++;
            $display("FAIL %s reset: credit=%0d expected=%0d", name, credit, e);
        end
    endtask

    task automatic test_reset();
        do_reset("reset_initial");
        do_reset("reset_repeat");
    endtask

    task automatic test_deposit();
        logic [7:0] stim[] = '{P, N, D, Q, Q, Q, Q, Q, Q, Q, Q, Q, Q, Q, P | N | D | Q};
        logic [7:0] want[] = '{8'd1, 8'd6, 8'd16, 8'd41, 8'd66, 8'd91, 8'd116, 8'd141,
                               8'd166, 8'd191, 8'd216, 8'd241, 8'd255, 8'd255, 8'd255};
        run_table("deposit", stim, want);
    endtask

    task automatic test_purchases();
        logic [7:0] stim[] = '{A, B, C, DT};
        logic [7:0] want[] = '{8'd180, 8'd160, 8'd130, 8'd90};
        run_table("purchases", stim, want);
    endtask

    task automatic test_unaffordable();
        logic [7:0] stim[] = '{Q | N, A, C, DT};
        logic [7:0] want[] = '{8'd30, 8'd30, 8'd0, 8'd0};
        do_reset("unaffordable");
        run_table("unaffordable", stim, want);
    endtask

    task automatic test_priority();
        logic [7:0] stim[] = '{Q, Q, D, A | B | C | DT};
        logic [7:0] want[] = '{8'd25, 8'd50, 8'd60, 8'd10};
        do_reset("priority");
        run_table("priority", stim, want);
    endtask

    task automatic test_coin_and_item();
        logic [7:0] stim[] = '{Q, Q, Q | A};
        logic [7:0] want[] = '{8'd25, 8'd50, 8'd0};
        do_reset("coin_and_item");
        run_table("coin_and_item", stim, want);
    endtask

    task automatic test_boundaries();
        logic [7:0] stim74[] = '{Q, Q, D, D, P, P, P, P, A, B, B, B, C};
        logic [7:0] want74[] = '{8'd25, 8'd50, 8'd60, 8'd70, 8'd71, 8'd72, 8'd73, 8'd74,
                                 8'd74, 8'd54, 8'd34, 8'd14, 8'd14};
        logic [7:0] stim_sat[] = '{Q, Q, Q, Q, Q, Q, Q, Q, Q, Q, Q, DT | C};
        logic [7:0] want_sat[] = '{8'd25, 8'd50, 8'd75, 8'd100, 8'd125, 8'd150, 8'd175,
                                   8'd200, 8'd225, 8'd250, 8'd255, 8'd185};
        logic [7:0] stim_eq[] = '{D, D, B};
        logic [7:0] want_eq[] = '{8'd10, 8'd20, 8'd0};
        do_reset("boundary_74");
        run_table("boundary_74", stim74, want74);
        do_reset("boundary_sat");
        run_table("boundary_sat", stim_sat, want_sat);
        do_reset("boundary_exact");
        run_table("boundary_exact", stim_eq, want_eq);
    endtask

    task automatic test_reset_override();
        logic [7:0] stim[] = '{Q, Q, Q, Q};
        logic [7:0] want[] = '{8'd25, 8'd50, 8'd75, 8'd100};
        logic [7:0] e;
        do_reset("reset_override");
        run_table("reset_override", stim, want);
        apply(1'b1, Q, 8'd0);
        e = exp_q.pop_front();
        checks++;
        if (credit !== e) begin
            errors++;
            $display("FAIL reset_override with_quarter: credit=%0d expected=%0d", credit, e);
        end
        apply(1'b0, P, 8'd1);
        e = exp_q.pop_front();
        checks++;
        if (credit !== e) begin
            errors++;
            $display("FAIL reset_override release_penny: credit=%0d expected=%0d", credit, e);
        end
    endtask

    // Randomized traffic against an integer reference model using the price and coin tables.
    task automatic test_random();
        int         coin_val[4]  = '{1, 5, 10, 25};
        int         price_val[4] = '{75, 20, 30, 40};
        int         model;
        logic [7:0] v;
        logic       r;
        logic [7:0] e;
        do_reset("random");
        model = 0;
        for (int n = 0; n < 400; n++) begin
            v = 8'($urandom);
            r = ($urandom_range(0, 31) == 0);
            if (r) begin
                model = 0;
            end else begin
                for (int k = 0; k < 4; k++) if (v[k]) model += coin_val[k];
                if (model > 255) model = 255;
                for (int k = 0; k < 4; k++)
                    if (v[4 + k] && model >= price_val[k]) model -= price_val[k];
            end
            apply(r, v, 8'(model));
            e = exp_q.pop_front();
            checks++;
            if (credit !== e) begin
                errors++;
                $display("FAIL random cycle %0d rst=%0b in=%02h: credit=%0d expected=%0d",
                         n, r, v, credit, e);
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        {penny, nickel, dime, quarter} = 4'b0;
        {apple, banana, carrot, date}  = 4'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_deposit();
        test_purchases();
        test_unaffordable();
        test_priority();
        test_coin_and_item();
        test_boundaries();
        test_reset_override();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
